exe_mem_pipe_reg: RTL and testbench

Parametrised EXE→MEM pipeline register for the MIPS multicycle core, replacing the fixed-width, always-loading stage latch. Carries the write-back/memory control bits, PC, ALU result, store value and destination register from EXE to MEM through a valid/ready handshake. A two-entry skid buffer keeps full throughput while registering `in_ready`. Adds synchronous flush (bubble insertion) and a saturating back-pressure stall counter for performance debug.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/skid_buffer.sv | 92 +++++++++
 rtl/exe_mem_pipe_reg.sv | 78 +++++++
 tb/tb_exe_mem_pipe_reg.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core types: datapath widths, EXE->MEM bundle
// and the skid buffer occupancy encoding.
package mips_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic                  wb_en;
        logic                  mem_r_en;
        logic                  mem_w_en;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       alu_result;
        logic [XLEN-1:0]       st_val;
        logic [REG_ADDR_W-1:0] dest;
    } exe_mem_t;

    // Bit 0 = main valid, bit 1 = skid valid.
    typedef enum logic [1:0] {
        SB_EMPTY = 2'b00,
        SB_FULL  = 2'b01,
        SB_SKID  = 2'b11
    } skid_state_t;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer with synchronous flush.
// in_ready and out_valid come straight from the state register.
module skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    import mips_pkg::*;

    skid_state_t      state_q;
    skid_state_t      state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             accept;
    logic             drain;
    logic             load_main;
    logic             load_skid;
    logic             main_from_skid;

    assign out_valid = (state_q != SB_EMPTY);
    assign in_ready  = (state_q != SB_SKID);
    assign out_data  = main_q;

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        unique case (state_q)
            SB_EMPTY: begin
                if (accept) begin
                    state_d   = SB_FULL;
                    load_main = 1'b1;
                end
            end
            SB_FULL: begin
                if (accept && drain) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    state_d   = SB_SKID;
                    load_skid = 1'b1;
                end else if (drain) begin
                    state_d = SB_EMPTY;
                end
            end
            SB_SKID: begin
                if (drain) begin
                    state_d        = SB_FULL;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = SB_EMPTY;
        endcase
        // Flush wins: drop both entries and ignore any incoming one.
        if (flush) begin
            state_d        = SB_EMPTY;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SB_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_main) begin
                main_q <= in_data;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/exe_mem_pipe_reg.sv
// EXE->MEM pipeline register: skid-buffered handshake, bubble-safe
// control outputs and a saturating back-pressure stall counter.
module exe_mem_pipe_reg #(
    parameter int XLEN       = mips_pkg::XLEN,
    parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  WB_en_in,
    input  logic                  MEM_R_EN_in,
    input  logic                  MEM_W_EN_in,
    input  logic [XLEN-1:0]       PC_in,
    input  logic [XLEN-1:0]       ALU_result_in,
    input  logic [XLEN-1:0]       ST_val_in,
    input  logic [REG_ADDR_W-1:0] Dest_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  WB_en,
    output logic                  MEM_R_EN,
    output logic                  MEM_W_EN,
    output logic [XLEN-1:0]       PC,
    output logic [XLEN-1:0]       ALU_result,
    output logic [XLEN-1:0]       ST_val,
    output logic [REG_ADDR_W-1:0] Dest,
    output logic [CNT_W-1:0]      stall_cnt
);
    import mips_pkg::*;

    exe_mem_t in_d;
    exe_mem_t out_d;

    always_comb begin
        in_d            = '0;
        in_d.wb_en      = WB_en_in;
        in_d.mem_r_en   = MEM_R_EN_in;
        in_d.mem_w_en   = MEM_W_EN_in;
        in_d.pc         = PC_in;
        in_d.alu_result = ALU_result_in;
        in_d.st_val     = ST_val_in;
        in_d.dest       = Dest_in;
    end

    skid_buffer #(
        .WIDTH($bits(exe_mem_t))
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_d),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_d)
    );

    // Bubbles must never write the register file or memory.
    assign WB_en      = out_valid & out_d.wb_en;
    assign MEM_R_EN   = out_valid & out_d.mem_r_en;
    assign MEM_W_EN   = out_valid & out_d.mem_w_en;
    assign PC         = out_d.pc;
    assign ALU_result = out_d.alu_result;
    assign ST_val     = out_d.st_val;
    assign Dest       = out_d.dest;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Scenario bench for exe_mem_pipe_reg with an in-order scoreboard.
module tb_exe_mem_pipe_reg;

    localparam int CW = 4;

    typedef struct packed {
        logic        wb;
        logic        mr;
        logic        mw;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] st;
        logic [4:0]  dest;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic          WB_en_in;
    logic          MEM_R_EN_in;
    logic          MEM_W_EN_in;
    logic [31:0]   PC_in;
    logic [31:0]   ALU_result_in;
    logic [31:0]   ST_val_in;
    logic [4:0]    Dest_in;
    logic          out_valid;
    logic          out_ready;
    logic          WB_en;
    logic          MEM_R_EN;
    logic          MEM_W_EN;
    logic [31:0]   PC;
    logic [31:0]   ALU_result;
    logic [31:0]   ST_val;
    logic [4:0]    Dest;
    logic [CW-1:0] stall_cnt;

    exe_mem_pipe_reg #(
        .XLEN(32),
        .REG_ADDR_W(5),
        .CNT_W(CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .WB_en_in     (WB_en_in),
        .MEM_R_EN_in  (MEM_R_EN_in),
        .MEM_W_EN_in  (MEM_W_EN_in),
        .PC_in        (PC_in),
        .ALU_result_in(ALU_result_in),
        .ST_val_in    (ST_val_in),
        .Dest_in      (Dest_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .WB_en        (WB_en),
        .MEM_R_EN     (MEM_R_EN),
        .MEM_W_EN     (MEM_W_EN),
        .PC           (PC),
        .ALU_result   (ALU_result),
        .ST_val       (ST_val),
        .Dest         (Dest),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    ent_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   nd;
    logic obs_drain;
    logic obs_acc;
    ent_t obs_ent;
    ent_t exp_ent;

    function automatic ent_t mk(input logic [31:0] pc);
        ent_t e;
        e.wb   = 1'($urandom);
        e.mr   = 1'($urandom);
        e.mw   = 1'($urandom);
        e.pc   = pc;
        e.alu  = $urandom;
        e.st   = $urandom;
        e.dest = 5'($urandom);
        return e;
    endfunction

    task automatic drive(input ent_t e, input logic v);
        {WB_en_in, MEM_R_EN_in, MEM_W_EN_in} = {e.wb, e.mr, e.mw};
        {PC_in, ALU_result_in, ST_val_in}     = {e.pc, e.alu, e.st};
        Dest_in  = e.dest;
        in_valid = v;
    endtask

    // One clock: sample pre-edge handshakes, update the scoreboard,
    // then return #1 after the edge.
    task automatic tick();
        @(negedge clk);
        obs_drain = out_valid && out_ready;
        obs_acc   = in_valid && in_ready;
        obs_ent   = {WB_en, MEM_R_EN, MEM_W_EN, PC, ALU_result, ST_val, Dest};
        if (rst || flush) begin
            sb.delete();
        end else if (obs_acc) begin
            sb.push_back({WB_en_in, MEM_R_EN_in, MEM_W_EN_in,
                          PC_in, ALU_result_in, ST_val_in, Dest_in});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive('0, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive('0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready);
        else n_pass++;
        n_total++;
        if ({WB_en, MEM_R_EN, MEM_W_EN} !== 3'b000)
            $display("FAIL reset_ctrl: got %b want 000", {WB_en, MEM_R_EN, MEM_W_EN});
        else n_pass++;
        n_total++;
        if ({PC, ALU_result, ST_val, Dest} !== '0)
            $display("FAIL reset_data: got %h want 0", {PC, ALU_result, ST_val, Dest});
        else n_pass++;
        n_total++;
        if (stall_cnt !== '0) $display("FAIL reset_cnt: got %0d want 0", stall_cnt);
        else n_pass++;
    endtask

    task automatic test_single();
        ent_t e;
        e = '{wb: 1'b1, mr: 1'b0, mw: 1'b0, pc: 32'h40, alu: 32'h1234, st: 32'h0, dest: 5'd7};
        out_ready = 1'b1;
        drive(e, 1'b1);
        tick();
        drive(e, 1'b0);
        n_total++;
        if ({out_valid, PC, Dest, WB_en} !== {1'b1, 32'h40, 5'd7, 1'b1})
            $display("FAIL single_out: got v=%b pc=%h d=%0d wb=%b want v=1 pc=40 d=7 wb=1",
                     out_valid, PC, Dest, WB_en);
        else n_pass++;
        tick();
        if (obs_drain) begin
            n_total++;
            if (sb.size() != 0) exp_ent = sb.pop_front();
            else exp_ent = 'x;
            if (obs_ent !== exp_ent) $display("FAIL single_data: got %h want %h", obs_ent, exp_ent);
            else n_pass++;
        end
        n_total++;
        if ({out_valid, WB_en} !== 2'b00)
            $display("FAIL single_bubble: got v=%b wb=%b want 0 0", out_valid, WB_en);
        else n_pass++;
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1;
        nd = 0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) drive(mk(32'(4 * i)), 1'b1);
            else drive('0, 1'b0);
            tick();
            if (obs_drain) begin
                n_total++;
                nd++;
                if (sb.size() != 0) exp_ent = sb.pop_front();
                else exp_ent = 'x;
                if (obs_ent !== exp_ent) $display("FAIL stream_data: got %h want %h", obs_ent, exp_ent);
                else n_pass++;
            end
            n_total++;
            if (in_ready !== 1'b1) $display("FAIL stream_ready: got %b want 1 at %0d", in_ready, i);
            else n_pass++;
        end
        n_total++;
        if (nd != 8) $display("FAIL stream_count: got %0d want 8", nd);
        else n_pass++;
        n_total++;
        if (stall_cnt !== '0) $display("FAIL stream_cnt: got %0d want 0", stall_cnt);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        ent_t e3;
        do_reset();
        drive(mk(32'h100), 1'b1);
        tick();
        drive(mk(32'h104), 1'b1);
        tick();
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL bp_ready_drop: got %b want 0", in_ready);
        else n_pass++;
        e3 = mk(32'h108);
        drive(e3, 1'b1);
        repeat (3) tick();
        n_total++;
        if (stall_cnt !== 4'd4) $display("FAIL bp_cnt_stall: got %0d want 4", stall_cnt);
        else n_pass++;
        out_ready = 1'b1;
        nd = 0;
        for (int c = 0; c < 10 && nd < 3; c++) begin
            tick();
            if (obs_acc) drive(e3, 1'b0);
            if (obs_drain) begin
                n_total++;
                nd++;
                if (sb.size() != 0) exp_ent = sb.pop_front();
                else exp_ent = 'x;
                if (obs_ent !== exp_ent) $display("FAIL bp_data: got %h want %h", obs_ent, exp_ent);
                else n_pass++;
            end
        end
        n_total++;
        if (nd != 3) $display("FAIL bp_count: got %0d want 3", nd);
        else n_pass++;
        n_total++;
        if (stall_cnt !== 4'd4) $display("FAIL bp_cnt_final: got %0d want 4", stall_cnt);
        else n_pass++;
    endtask

    task automatic test_flush();
        ent_t e;
        do_reset();
        e = mk(32'h200);
        e.mw = 1'b1;
        drive(e, 1'b1);
        tick();
        e.pc = 32'h204;
        drive(e, 1'b1);
        tick();
        drive(mk(32'h208), 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive('0, 1'b0);
        n_total++;
        if ({out_valid, MEM_W_EN, in_ready} !== 3'b001)
            $display("FAIL flush_skid: got v=%b mw=%b rdy=%b want 0 0 1",
                     out_valid, MEM_W_EN, in_ready);
        else n_pass++;
        n_total++;
        if (stall_cnt !== 4'd2) $display("FAIL flush_cnt: got %0d want 2", stall_cnt);
        else n_pass++;
        out_ready = 1'b1;
        drive(mk(32'h20c), 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive('0, 1'b0);
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL flush_accept: got %b want 0", out_valid);
        else n_pass++;
        nd = 0;
        repeat (2) begin
            tick();
            if (obs_drain) nd++;
        end
        drive(mk(32'h210), 1'b1);
        tick();
        drive('0, 1'b0);
        tick();
        if (obs_drain) begin
            nd++;
            n_total++;
            if (sb.size() != 0) exp_ent = sb.pop_front();
            else exp_ent = 'x;
            if (obs_ent !== exp_ent) $display("FAIL flush_next: got %h want %h", obs_ent, exp_ent);
            else n_pass++;
        end
        n_total++;
        if (nd != 1) $display("FAIL flush_count: got %0d want 1", nd);
        else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        drive(mk(32'h300), 1'b1);
        tick();
        drive('0, 1'b0);
        repeat (20) tick();
        n_total++;
        if (stall_cnt !== 4'd15) $display("FAIL sat_cnt: got %0d want 15", stall_cnt);
        else n_pass++;
        n_total++;
        if ({out_valid, PC} !== {1'b1, 32'h300})
            $display("FAIL sat_hold: got v=%b pc=%h want 1 300", out_valid, PC);
        else n_pass++;
        out_ready = 1'b1;
        tick();
        if (obs_drain) begin
            n_total++;
            if (sb.size() != 0) exp_ent = sb.pop_front();
            else exp_ent = 'x;
            if (obs_ent !== exp_ent) $display("FAIL sat_data: got %h want %h", obs_ent, exp_ent);
            else n_pass++;
        end
        n_total++;
        if (stall_cnt !== 4'd15) $display("FAIL sat_after: got %0d want 15", stall_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(mk(32'h400), 1'b1);
        tick();
        drive(mk(32'h404), 1'b1);
        tick();
        drive(mk(32'h408), 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive('0, 1'b0);
        n_total++;
        if ({out_valid, in_ready, WB_en, MEM_R_EN, MEM_W_EN} !== 5'b01000)
            $display("FAIL rstmid_ctl: got %b want 01000",
                     {out_valid, in_ready, WB_en, MEM_R_EN, MEM_W_EN});
        else n_pass++;
        n_total++;
        if ({PC, ALU_result, ST_val, Dest, stall_cnt} !== '0)
            $display("FAIL rstmid_data: got %h want 0", {PC, ALU_result, ST_val, Dest, stall_cnt});
        else n_pass++;
        out_ready = 1'b1;
        drive(mk(32'h40c), 1'b1);
        tick();
        drive('0, 1'b0);
        nd = 0;
        repeat (2) begin
            tick();
            if (obs_drain) begin
                nd++;
                n_total++;
                if (sb.size() != 0) exp_ent = sb.pop_front();
                else exp_ent = 'x;
                if (obs_ent !== exp_ent) $display("FAIL rstmid_next: got %h want %h", obs_ent, exp_ent);
                else n_pass++;
            end
        end
        n_total++;
        if (nd != 1) $display("FAIL rstmid_count: got %0d want 1", nd);
        else n_pass++;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive('0, 1'b0);
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_flush();
        test_saturation();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
